// File: rtl/riscv_idex_stage.sv
// riscv_idex_stage: ID/EX pipeline register with load-use stall detection, flush/hold control and event counters.
module riscv_idex_stage #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_idex_valid,
  input  logic            i_idex_reg_wr_en,
  input  logic            i_idex_result_src,
  input  logic [1:0]      i_idex_mux_sel,
  input  logic            i_idex_mem_wr_en,
  input  logic            i_idex_jal,
  input  logic            i_idex_jalr,
  input  logic            i_idex_branch,
  input  logic [3:0]      i_idex_alu_ctrl,
  input  logic            i_idex_alu_src,
  input  logic [3:0]      i_idex_mem_byte_sel,
  input  logic [2:0]      i_idex_funct3,
  input  logic [XLEN-1:0] i_idex_pc,
  input  logic [XLEN-1:0] i_idex_pc4,
  input  logic [XLEN-1:0] i_idex_rs1_data,
  input  logic [XLEN-1:0] i_idex_rs2_data,
  input  logic [XLEN-1:0] i_idex_imm,
  input  logic [4:0]      i_idex_rs1_addr,
  input  logic [4:0]      i_idex_rs2_addr,
  input  logic [4:0]      i_idex_rd_addr,
  input  logic            i_idex_flush,
  input  logic            i_idex_hold,
  output logic            o_idex_valid,
  output logic            o_idex_reg_wr_en,
  output logic            o_idex_result_src,
  output logic [1:0]      o_idex_mux_sel,
  output logic            o_idex_mem_wr_en,
  output logic            o_idex_jal,
  output logic            o_idex_jalr,
  output logic            o_idex_branch,
  output logic [3:0]      o_idex_alu_ctrl,
  output logic            o_idex_alu_src,
  output logic [3:0]      o_idex_mem_byte_sel,
  output logic [2:0]      o_idex_funct3,
  output logic [XLEN-1:0] o_idex_pc,
  output logic [XLEN-1:0] o_idex_pc4,
  output logic [XLEN-1:0] o_idex_rs1_data,
  output logic [XLEN-1:0] o_idex_rs2_data,
  output logic [XLEN-1:0] o_idex_imm,
  output logic [4:0]      o_idex_rs1_addr,
  output logic [4:0]      o_idex_rs2_addr,
  output logic [4:0]      o_idex_rd_addr,
  output logic            o_idex_stall,
  output logic [31:0]     o_idex_stall_cnt,
  output logic [31:0]     o_idex_flush_cnt
);
  localparam int W = 36 + 5 * XLEN;
  logic [W-1:0] d, q, bub;
  logic [31:0] stall_cnt, flush_cnt;
  logic lu;
  assign d = {i_idex_valid, i_idex_reg_wr_en, i_idex_result_src, i_idex_mux_sel, i_idex_mem_wr_en,
              i_idex_jal, i_idex_jalr, i_idex_branch, i_idex_alu_ctrl, i_idex_alu_src,
              i_idex_mem_byte_sel, i_idex_funct3, i_idex_pc, i_idex_pc4, i_idex_rs1_data,
              i_idex_rs2_data, i_idex_imm, i_idex_rs1_addr, i_idex_rs2_addr, i_idex_rd_addr};
  // Bubble is all-zero except the byte-select field, which idles at all-lanes.
  assign bub = {14'b0, 4'hF, {(5 * XLEN + 18){1'b0}}};
  assign {o_idex_valid, o_idex_reg_wr_en, o_idex_result_src, o_idex_mux_sel, o_idex_mem_wr_en,
          o_idex_jal, o_idex_jalr, o_idex_branch, o_idex_alu_ctrl, o_idex_alu_src,
          o_idex_mem_byte_sel, o_idex_funct3, o_idex_pc, o_idex_pc4, o_idex_rs1_data,
          o_idex_rs2_data, o_idex_imm, o_idex_rs1_addr, o_idex_rs2_addr, o_idex_rd_addr} = q;
  assign lu = o_idex_valid & o_idex_reg_wr_en & ~o_idex_result_src & (o_idex_rd_addr != 5'd0) &
              i_idex_valid & ((o_idex_rd_addr == i_idex_rs1_addr) | (o_idex_rd_addr == i_idex_rs2_addr));
  assign o_idex_stall = ~i_idex_flush & (i_idex_hold | lu);
  assign o_idex_stall_cnt = stall_cnt;
  assign o_idex_flush_cnt = flush_cnt;
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      q <= bub;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      q <= i_idex_flush ? bub : i_idex_hold ? q : lu ? bub : d;
      if (lu & ~i_idex_flush & ~i_idex_hold & ~&stall_cnt) stall_cnt <= stall_cnt + 32'd1;
      if (i_idex_flush & ~&flush_cnt) flush_cnt <= flush_cnt + 32'd1;
    end
  end
endmodule

// File: tb/tb_riscv_idex_stage.sv
// tb_riscv_idex_stage: directed vectors, expected EX-stage state queued per cycle and checked by a monitor.
module tb_riscv_idex_stage;
  logic clk = 1'b0, rstn = 1'b0;
  always #5 clk = ~clk;
  logic v, wr, rsrc, mwr, jal, jalr, br, asrc, flush, hold;
  logic [1:0] msel;
  logic [3:0] actl, bsel;
  logic [2:0] f3;
  logic [31:0] pc, pc4, r1d, r2d, imm;
  logic [4:0] ra1, ra2, rd;
  logic o_v, o_wr, o_rsrc, o_mwr, o_jal, o_jalr, o_br, o_asrc, o_stall;
  logic [1:0] o_msel;
  logic [3:0] o_actl, o_bsel;
  logic [2:0] o_f3;
  logic [31:0] o_pc, o_pc4, o_r1d, o_r2d, o_imm, o_sc, o_fc;
  logic [4:0] o_ra1, o_ra2, o_rd;

  riscv_idex_stage #(.XLEN(32)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_idex_valid(v), .i_idex_reg_wr_en(wr), .i_idex_result_src(rsrc),
    .i_idex_mux_sel(msel), .i_idex_mem_wr_en(mwr), .i_idex_jal(jal), .i_idex_jalr(jalr),
    .i_idex_branch(br), .i_idex_alu_ctrl(actl), .i_idex_alu_src(asrc), .i_idex_mem_byte_sel(bsel),
    .i_idex_funct3(f3), .i_idex_pc(pc), .i_idex_pc4(pc4), .i_idex_rs1_data(r1d),
    .i_idex_rs2_data(r2d), .i_idex_imm(imm), .i_idex_rs1_addr(ra1), .i_idex_rs2_addr(ra2),
    .i_idex_rd_addr(rd), .i_idex_flush(flush), .i_idex_hold(hold),
    .o_idex_valid(o_v), .o_idex_reg_wr_en(o_wr), .o_idex_result_src(o_rsrc), .o_idex_mux_sel(o_msel),
    .o_idex_mem_wr_en(o_mwr), .o_idex_jal(o_jal), .o_idex_jalr(o_jalr), .o_idex_branch(o_br),
    .o_idex_alu_ctrl(o_actl), .o_idex_alu_src(o_asrc), .o_idex_mem_byte_sel(o_bsel),
    .o_idex_funct3(o_f3), .o_idex_pc(o_pc), .o_idex_pc4(o_pc4), .o_idex_rs1_data(o_r1d),
    .o_idex_rs2_data(o_r2d), .o_idex_imm(o_imm), .o_idex_rs1_addr(o_ra1), .o_idex_rs2_addr(o_ra2),
    .o_idex_rd_addr(o_rd), .o_idex_stall(o_stall), .o_idex_stall_cnt(o_sc), .o_idex_flush_cnt(o_fc)
  );

  typedef struct {
    logic s, v, wr;
    logic [31:0] pc, sc, fc;
    logic [4:0] rd;
    logic [3:0] bs;
  } exp_t;
  exp_t sq[$];
  int total = 0, passed = 0;
  localparam logic [3:0] B = 4'hF, C = 4'h3;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h expected %h", n, a, e);
  endtask

  task automatic set_id(input logic iv, input logic iwr, input logic irs, input logic [31:0] ipc,
                        input logic [4:0] i1, input logic [4:0] i2, input logic [4:0] ird);
    v = iv; wr = iwr; rsrc = irs; pc = ipc; pc4 = ipc + 32'd4; ra1 = i1; ra2 = i2; rd = ird;
    r1d = ipc ^ 32'h1111; r2d = ipc ^ 32'h2222; imm = ipc + 32'h10;
  endtask

  task automatic cyc(input logic f, input logic h, input logic es, input logic ev, input logic [31:0] epc,
                     input logic [4:0] erd, input logic [3:0] ebs, input logic ewr,
                     input logic [31:0] esc, input logic [31:0] efc);
    exp_t e;
    flush = f; hold = h;
    e.s = es; e.v = ev; e.pc = epc; e.rd = erd; e.bs = ebs; e.wr = ewr; e.sc = esc; e.fc = efc;
    sq.push_back(e);
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    logic s;
    forever begin
      @(negedge clk);
      #2;
      if (sq.size() != 0) begin
        s = o_stall;
        @(posedge clk);
        #1;
        e = sq.pop_front();
        chk("stall", {31'b0, s}, {31'b0, e.s});
        chk("valid", {31'b0, o_v}, {31'b0, e.v});
        chk("pc", o_pc, e.pc);
        chk("rd", {27'b0, o_rd}, {27'b0, e.rd});
        chk("byte_sel", {28'b0, o_bsel}, {28'b0, e.bs});
        chk("reg_wr_en", {31'b0, o_wr}, {31'b0, e.wr});
        chk("stall_cnt", o_sc, e.sc);
        chk("flush_cnt", o_fc, e.fc);
      end
    end
  end

  initial begin
    flush = 0; hold = 0; msel = 2'b01; mwr = 0; jal = 0; jalr = 0; br = 0; actl = 4'h2; asrc = 0;
    bsel = C; f3 = 3'h2;
    set_id(0, 0, 0, 32'h0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'b0, o_v}, 32'd0);
    chk("rst_byte_sel", {28'b0, o_bsel}, 32'hF);
    chk("rst_pc", o_pc, 32'd0);
    chk("rst_stall_cnt", o_sc, 32'd0);
    chk("rst_flush_cnt", o_fc, 32'd0);
    chk("rst_stall", {31'b0, o_stall}, 32'd0);
    rstn = 1;
    set_id(1, 1, 0, 32'h10, 1, 2, 5);   cyc(0, 0, 0, 1, 32'h10, 5, C, 1, 1 - 1, 0);
    set_id(1, 1, 1, 32'h14, 5, 6, 7);   cyc(0, 0, 1, 0, 0, 0, B, 0, 1, 0);
                                        cyc(0, 0, 0, 1, 32'h14, 7, C, 1, 1, 0);
    set_id(1, 1, 0, 32'h18, 3, 4, 0);   cyc(0, 0, 0, 1, 32'h18, 0, C, 1, 1, 0);
    set_id(1, 1, 1, 32'h1c, 0, 0, 8);   cyc(0, 0, 0, 1, 32'h1c, 8, C, 1, 1, 0);
    set_id(1, 1, 1, 32'h100, 1, 2, 9);  cyc(1, 0, 0, 0, 0, 0, B, 0, 1, 1);
    set_id(1, 1, 1, 32'h40, 1, 2, 10);  cyc(0, 0, 0, 1, 32'h40, 10, C, 1, 1, 1);
    set_id(1, 1, 1, 32'h44, 10, 0, 11);
    repeat (3)                          cyc(0, 1, 1, 1, 32'h40, 10, C, 1, 1, 1);
                                        cyc(0, 0, 0, 1, 32'h44, 11, C, 1, 1, 1);
    set_id(0, 1, 0, 32'h48, 1, 1, 12);  cyc(0, 0, 0, 0, 32'h48, 12, C, 1, 1, 1);
    set_id(1, 1, 1, 32'h4c, 12, 0, 13); cyc(0, 0, 0, 1, 32'h4c, 13, C, 1, 1, 1);
    set_id(1, 1, 0, 32'h50, 2, 3, 14);  cyc(0, 0, 0, 1, 32'h50, 14, C, 1, 1, 1);
    set_id(1, 1, 1, 32'h54, 14, 14, 15);
                                        cyc(0, 1, 1, 1, 32'h50, 14, C, 1, 1, 1);
                                        cyc(1, 1, 0, 0, 0, 0, B, 0, 1, 2);
                                        cyc(0, 0, 0, 1, 32'h54, 15, C, 1, 1, 2);
    force dut.stall_cnt = 32'hFFFF_FFFE;
    #1 release dut.stall_cnt;
    set_id(1, 1, 0, 32'h58, 1, 1, 5);   cyc(0, 0, 0, 1, 32'h58, 5, C, 1, 32'hFFFF_FFFE, 2);
    set_id(1, 1, 0, 32'h5c, 5, 1, 6);   cyc(0, 0, 1, 0, 0, 0, B, 0, 32'hFFFF_FFFF, 2);
                                        cyc(0, 0, 0, 1, 32'h5c, 6, C, 1, 32'hFFFF_FFFF, 2);
    set_id(1, 1, 0, 32'h60, 6, 1, 7);   cyc(0, 0, 1, 0, 0, 0, B, 0, 32'hFFFF_FFFF, 2);
                                        cyc(0, 0, 0, 1, 32'h60, 7, C, 1, 32'hFFFF_FFFF, 2);
    set_id(1, 1, 1, 32'h64, 1, 7, 8);   cyc(0, 0, 1, 0, 0, 0, B, 0, 32'hFFFF_FFFF, 2);
                                        cyc(0, 0, 0, 1, 32'h64, 8, C, 1, 32'hFFFF_FFFF, 2);
    set_id(1, 1, 0, 32'h68, 1, 1, 9);   cyc(0, 0, 0, 1, 32'h68, 9, C, 1, 32'hFFFF_FFFF, 2);
    set_id(1, 1, 1, 32'h6c, 9, 0, 10);
    #1 chk("pre_rst_stall", {31'b0, o_stall}, 32'd1);
    #1 rstn = 0;
    #1;
    chk("mid_rst_stall", {31'b0, o_stall}, 32'd0);
    chk("mid_rst_valid", {31'b0, o_v}, 32'd0);
    chk("mid_rst_byte_sel", {28'b0, o_bsel}, 32'hF);
    chk("mid_rst_pc", o_pc, 32'd0);
    chk("mid_rst_stall_cnt", o_sc, 32'd0);
    chk("mid_rst_flush_cnt", o_fc, 32'd0);
    @(negedge clk);
    rstn = 1;
                                        cyc(0, 0, 0, 1, 32'h6c, 10, C, 1, 0, 0);
    repeat (2) @(negedge clk);
    chk("drain", sq.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/riscv_idex_stage.md
RISCV_IDEX_STAGE -- requirements
Module: riscv_idex_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have i_clk  input  1  single clock, rising edge.
REQ-003 SHALL have i_rstn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have i_idex_valid  input  1  ID holds a real instruction.
REQ-005 SHALL have ID control inputs: i_idex_reg_wr_en 1, i_idex_result_src 1, i_idex_mux_sel 2, i_idex_mem_wr_en 1, i_idex_jal 1, i_idex_jalr 1, i_idex_branch 1, i_idex_alu_ctrl 4, i_idex_alu_src 1, i_idex_mem_byte_sel 4, i_idex_funct3 3.
REQ-006 SHALL have ID data inputs: i_idex_pc XLEN, i_idex_pc4 XLEN, i_idex_rs1_data XLEN, i_idex_rs2_data XLEN, i_idex_imm XLEN, i_idex_rs1_addr 5, i_idex_rs2_addr 5, i_idex_rd_addr 5.
REQ-007 SHALL have i_idex_flush  input  1  EX redirect (taken branch, JAL, JALR).
REQ-008 SHALL have i_idex_hold  input  1  downstream freeze request.
REQ-009 SHALL have an o_ registered copy of every REQ-005/REQ-006 input, same width, plus o_idex_valid  output  1.
REQ-010 SHALL have o_idex_stall  output  1  IF/ID must hold, combinational.
REQ-011 SHALL have o_idex_stall_cnt  output  32  load-use stall cycles; o_idex_flush_cnt  output  32  flush cycles.

Function
REQ-012 Load-use hazard lu SHALL be o_idex_valid & o_idex_reg_wr_en & ~o_idex_result_src & (o_idex_rd_addr != 0) & i_idex_valid & ((o_idex_rd_addr == i_idex_rs1_addr) | (o_idex_rd_addr == i_idex_rs2_addr)).
REQ-013 Both rs fields SHALL be compared regardless of instruction format (conservative).
REQ-014 o_idex_stall SHALL equal ~i_idex_flush & (i_idex_hold | lu).
REQ-015 Per rising edge, priority flush > hold > lu > load: flush loads bubble; hold keeps all registered outputs; lu loads bubble; otherwise all inputs are captured.
REQ-016 Bubble SHALL be: o_idex_valid=0, o_idex_mem_byte_sel=4'b1111, every other registered output 0.
REQ-017 Captured instruction SHALL appear on outputs exactly 1 cycle after capture edge; no other latency.
REQ-018 i_idex_valid=0 while loading SHALL capture inputs with o_idex_valid=0; write enables pass unmodified, and the consumer SHALL qualify them with o_idex_valid.
REQ-019 lu bubble releases the stall in the following cycle (EX then holds the bubble), so a load-use pair costs exactly 1 stall cycle.
REQ-020 o_idex_stall_cnt SHALL increment on each edge where lu & ~i_idex_flush & ~i_idex_hold, saturating at 32'hFFFF_FFFF.
REQ-021 o_idex_flush_cnt SHALL increment on each edge with i_idex_flush=1, regardless of hold, saturating at 32'hFFFF_FFFF.
REQ-022 Flush and hold asserted together SHALL load the bubble and drive o_idex_stall=0.
REQ-023 Hold SHALL not mask lu detection, but stall_cnt SHALL not count during hold.

Reset
REQ-024 i_rstn low SHALL immediately force all registered outputs to bubble values (REQ-016) and both counters to 0, independent of i_clk.
REQ-025 Reset assertion mid-stall SHALL drop o_idex_stall to ~i_idex_flush & i_idex_hold in the same cycle, because o_idex_valid=0 clears lu.
REQ-026 First capture SHALL occur on the first rising edge after i_rstn deasserts.

Verification
REQ-027 lw x5 in EX (result_src=0, rd=5, valid), ID add rs1=5 -> o_idex_stall=1 for one cycle, bubble in EX next cycle, add captured the cycle after, stall_cnt=1.
REQ-028 lw rd=0 in EX, ID rs1=0 -> o_idex_stall=0, no bubble, stall_cnt=0.
REQ-029 i_idex_flush=1 with ID sub pc=0x100 -> next cycle o_idex_valid=0, o_idex_mem_byte_sel=4'b1111, o_idex_pc=0, flush_cnt=1.
REQ-030 i_idex_hold=1 for 3 cycles with addi pc=0x40 in EX -> outputs stay pc=0x40 for 3 cycles, o_idex_stall=1 each cycle, stall_cnt unchanged.
REQ-031 lu, hold and flush all asserted on one edge -> bubble loaded, o_idex_stall=0, flush_cnt+1, stall_cnt unchanged.
REQ-032 Preload stall_cnt to 32'hFFFF_FFFE, apply 3 lu cycles -> reads 32'hFFFF_FFFF; then i_rstn pulsed low mid-cycle -> counters 0 and o_idex_valid=0 immediately.
